// File: rtl/rr_grant_scheduler.sv
// Round-robin owner scheduler: one registered one-hot grant, held until the owner drops req or the watchdog revokes it.
// Grant appears the cycle after a winning req is sampled; every release is followed by exactly one idle gap cycle.
module rr_grant_scheduler #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3,
    parameter int TO_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             to_en,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy_own,
    output logic             timeout,
    output logic [IDX_W-1:0] to_idx
);

    localparam int SW = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_grant,   w_grant_nxt;
    logic [IDX_W-1:0]  r_idx,     w_idx_nxt;
    logic [IDX_W-1:0]  r_ptr,     w_ptr_nxt;
    logic [TO_W-1:0]   r_cnt,     w_cnt_nxt;
    logic              r_timeout, w_timeout_nxt;
    logic [IDX_W-1:0]  r_to_idx,  w_to_idx_nxt;
    logic [WIDTH-1:0]  r_blocked, w_blk_set;

    logic [WIDTH-1:0]  w_elig;
    logic [SW-1:0]     w_sum;
    logic              w_found;
    logic [IDX_W-1:0]  w_sel;
    logic [IDX_W-1:0]  w_idx_inc;

    // First eligible requester at or after ptr, wrapping without assuming a power-of-2 WIDTH.
    always_comb begin
        w_elig  = req & ~r_blocked;
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int k = 0; k < WIDTH; k++) begin
            w_sum = {1'b0, r_ptr} + SW'(k);
            if (w_sum >= SW'(WIDTH)) begin
                w_sum = w_sum - SW'(WIDTH);
            end
            if (!w_found && w_elig[w_sum[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[IDX_W-1:0];
            end
        end
    end

    assign w_idx_inc = (r_idx == IDX_W'(WIDTH - 1)) ? '0 : r_idx + IDX_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_idx_nxt     = r_idx;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        w_to_idx_nxt  = r_to_idx;
        w_blk_set     = '0;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (enable && w_found) begin
                    w_grant_nxt = WIDTH'(1) << w_sel;
                    w_idx_nxt   = w_sel;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_grant_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // A release wins over a watchdog expiry in the same cycle.
                if (!req[r_idx]) begin
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_idx_inc;
                    w_state_nxt = ST_GAP;
                end else if (to_en && (&r_cnt)) begin
                    w_grant_nxt          = '0;
                    w_timeout_nxt        = 1'b1;
                    w_to_idx_nxt         = r_idx;
                    w_blk_set[r_idx]     = 1'b1;
                    w_ptr_nxt            = w_idx_inc;
                    w_state_nxt          = ST_GAP;
                end else if (!(&r_cnt)) begin
                    w_cnt_nxt = r_cnt + TO_W'(1);
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_to_idx  <= '0;
            r_blocked <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_idx     <= w_idx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
            r_to_idx  <= w_to_idx_nxt;
            // A requester is unblocked only by dropping req; a fresh revoke wins.
            r_blocked <= (r_blocked & req) | w_blk_set;
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_idx;
    assign busy_own  = (r_state == ST_GRANT);
    assign timeout   = r_timeout;
    assign to_idx    = r_to_idx;

endmodule
